// File: rtl/prog_pkg.sv
// prog_pkg: shared FSM state type, programmer data width and default timing parameters
package prog_pkg;
  localparam int PD_W               = 8;
  localparam int SETUP_CYCLES_DEF   = 2;
  localparam int TIMEOUT_CYCLES_DEF = 1_000_000;
  typedef enum logic [2:0] {IDLE, SETUP, STRB_HI, STRB_LO, ERROR} state_e;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous bit
// ports: clk, rst_n (async active-low), d (async input), q (synchronized output)
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {sync_q, meta_q} <= '0;
    else        {sync_q, meta_q} <= {meta_q, d};
  assign q = sync_q;
endmodule

// File: rtl/prog_readback_tx.sv
// prog_readback_tx: sends 32-bit words little-endian as bytes over a 4-phase strobe/ack link
// ports: clk, rst_n (async active-low); word_in/word_last/word_valid/word_ready source side;
//        pd_data/pd_strb/pd_last out and pd_ack in (asynchronous) programmer side;
//        clr_err leaves ERROR; busy = not IDLE; timeout_err = sticky handshake timeout
module prog_readback_tx
  import prog_pkg::*;
#(
  parameter int SETUP_CYCLES   = SETUP_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     word_in,
  input  logic            word_last,
  input  logic            word_valid,
  output logic            word_ready,
  input  logic            pd_ack,
  output logic [PD_W-1:0] pd_data,
  output logic            pd_strb,
  output logic            pd_last,
  input  logic            clr_err,
  output logic            busy,
  output logic            timeout_err
);
  localparam int CMAX = TIMEOUT_CYCLES > SETUP_CYCLES ? TIMEOUT_CYCLES : SETUP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  state_e          state_q, state_d;
  logic [31:0]     word_q, word_d;
  logic            last_q, last_d;
  logic [1:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PD_W-1:0] pd_data_q, pd_data_d;
  logic            word_ready_q, word_ready_d, pd_strb_q, pd_strb_d, pd_last_q, pd_last_d;
  logic            busy_q, busy_d, timeout_err_q, timeout_err_d;
  logic            ack_s, tmo_hit;
  sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .d(pd_ack), .q(ack_s));
  always_comb begin
    tmo_hit = cnt_q == CW'(TIMEOUT_CYCLES - 1);
    state_d = state_q;
    word_d  = word_q;
    last_d  = last_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE:    if (word_valid && word_ready_q) begin
                 state_d = SETUP;
                 word_d  = word_in;
                 last_d  = word_last;
                 idx_d   = '0;
               end
      SETUP:   if (cnt_q == CW'(SETUP_CYCLES - 1)) state_d = STRB_HI;
      STRB_HI: state_d = ack_s ? STRB_LO : tmo_hit ? ERROR : STRB_HI;
      STRB_LO: if (!ack_s) begin
                 state_d = idx_q == 2'd3 ? IDLE : SETUP;
                 idx_d   = idx_q + 2'd1;
               end else if (tmo_hit) state_d = ERROR;
      ERROR:   if (clr_err) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // one counter serves both the setup delay and the handshake timeout; it restarts on every state change
    cnt_d         = state_d != state_q ? '0 : cnt_q + CW'(1);
    word_ready_d  = state_d == IDLE;
    busy_d        = state_d != IDLE;
    pd_strb_d     = state_d == STRB_HI;
    timeout_err_d = state_d == ERROR;
    pd_last_d     = last_d && idx_d == 2'd3 && (state_d == SETUP || state_d == STRB_HI);
    // data only moves on entry to SETUP, so it is always settled before the strobe rises
    pd_data_d     = (state_d == SETUP && state_q != SETUP) ? word_d[{idx_d, 3'b000} +: PD_W] : pd_data_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q       <= IDLE;
      word_q        <= '0;
      last_q        <= 1'b0;
      idx_q         <= '0;
      cnt_q         <= '0;
      pd_data_q     <= '0;
      word_ready_q  <= 1'b0;
      pd_strb_q     <= 1'b0;
      pd_last_q     <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      last_q        <= last_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      pd_data_q     <= pd_data_d;
      word_ready_q  <= word_ready_d;
      pd_strb_q     <= pd_strb_d;
      pd_last_q     <= pd_last_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  assign word_ready  = word_ready_q;
  assign pd_data     = pd_data_q;
  assign pd_strb     = pd_strb_q;
  assign pd_last     = pd_last_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_prog_readback_tx.sv
// tb_prog_readback_tx: directed self-checking bench for prog_readback_tx
module tb_prog_readback_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst_n, word_valid, word_last, pd_ack, clr_err;
  logic [31:0] word_in;
  logic        word_ready, pd_strb, pd_last, busy, timeout_err;
  logic [7:0]  pd_data;
  logic        t_valid, t_clr, t_ready, t_strb, t_last, t_busy, t_err;
  logic [7:0]  t_data;
  int          checks = 0, errors = 0, ack_dly = 0, stable = 0;
  bit          ack_rand = 1'b0;
  logic        prev_strb = 1'b0;
  logic [7:0]  prev_data = '0;
  logic [8:0]  bq[$];

  prog_readback_tx dut (
    .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_last(word_last),
    .word_valid(word_valid), .word_ready(word_ready), .pd_ack(pd_ack),
    .pd_data(pd_data), .pd_strb(pd_strb), .pd_last(pd_last), .clr_err(clr_err),
    .busy(busy), .timeout_err(timeout_err)
  );
  prog_readback_tx #(.SETUP_CYCLES(2), .TIMEOUT_CYCLES(16)) dut_to (
    .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_last(word_last),
    .word_valid(t_valid), .word_ready(t_ready), .pd_ack(1'b0),
    .pd_data(t_data), .pd_strb(t_strb), .pd_last(t_last), .clr_err(t_clr),
    .busy(t_busy), .timeout_err(t_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!word_ready && n < 3000) begin
      tick();
      n++;
    end
    chk(tag, word_ready, 1);
  endtask

  task automatic send(input logic [31:0] w, input logic l);
    wait_ready("ready_before_send");
    word_in    = w;
    word_last  = l;
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
  endtask

  task automatic chk_bytes(input string tag, input int cnt, input logic [71:0] exp);
    logic [8:0] got;
    chk({tag, "_count"}, bq.size(), cnt);
    for (int i = 0; i < cnt; i++) begin
      got = (i < bq.size()) ? bq[i] : 9'h1FF;
      chk(tag, {23'd0, got}, {23'd0, exp[9*i +: 9]});
    end
  endtask

  // programmer model: follows pd_strb on pd_ack after an optional random delay
  initial begin
    pd_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pd_ack  = 1'b0;
        ack_dly = 0;
      end else if (pd_ack != pd_strb) begin
        if (ack_dly > 0) ack_dly--;
        else begin
          pd_ack  = pd_strb;
          ack_dly = ack_rand ? int'($urandom_range(20, 0)) : 0;
        end
      end
    end
  end

  // link monitor: data held under strobe, settled before each rise, bytes logged with pd_last
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_strb = 1'b0;
      prev_data = '0;
      stable    = 0;
    end else begin
      stable = (pd_data == prev_data) ? stable + 1 : 1;
      if (pd_strb && !prev_strb) begin
        chk("setup_stable", stable >= 3, 1);
        bq.push_back({pd_last, pd_data});
      end
      if (pd_strb && prev_strb) chk("hold_under_strb", pd_data, prev_data);
      prev_strb = pd_strb;
      prev_data = pd_data;
    end
  end

  initial begin
    int n;
    logic [31:0] w;
    rst_n = 1'b0; word_valid = 1'b0; word_in = '0; word_last = 1'b0;
    clr_err = 1'b0; t_valid = 1'b0; t_clr = 1'b0;
    tick();
    tick();
    chk("rst_ready", word_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strb", pd_strb, 0);
    chk("rst_data", pd_data, 0);
    chk("rst_last", pd_last, 0);
    chk("rst_err", timeout_err, 0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_release", word_ready, 1);

    bq.delete();
    send(32'hA1B2C3D4, 1'b1);
    chk("busy_after_accept", busy, 1);
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_ignored_busy", busy, 1);
    chk("clr_ignored_err", timeout_err, 0);
    wait_ready("idle_after_a1");
    chk("idle_busy", busy, 0);
    chk_bytes("le_bytes", 4, {36'd0, 9'h1A1, 9'h0B2, 9'h0C3, 9'h0D4});

    bq.delete();
    word_in = 32'h11223344; word_last = 1'b0; word_valid = 1'b1;
    tick();
    chk("b2b_first_accept", busy, 1);
    word_in = 32'h55667788; word_last = 1'b1;
    n = 0;
    while (!word_ready && n < 3000) begin
      tick();
      n++;
    end
    chk("b2b_idle_seen", word_ready, 1);
    tick();
    chk("b2b_second_busy", busy, 1);
    chk("b2b_second_ready", word_ready, 0);
    word_valid = 1'b0;
    wait_ready("b2b_done");
    chk_bytes("b2b_bytes", 8, {9'h155, 9'h066, 9'h077, 9'h088, 9'h011, 9'h022, 9'h033, 9'h044});

    ack_rand = 1'b1;
    for (int k = 0; k < 64; k++) begin
      bq.delete();
      w = $urandom;
      send(w, k == 63);
      wait_ready("rnd_done");
      chk_bytes("rnd_bytes", 4, {36'd0, k == 63, w[31:24], 1'b0, w[23:16], 1'b0, w[15:8], 1'b0, w[7:0]});
    end
    ack_rand = 1'b0;

    word_in = 32'hDEADBEEF; word_last = 1'b1; t_valid = 1'b1;
    tick();
    t_valid = 1'b0;
    chk("to_accept_busy", t_busy, 1);
    n = 0;
    while (!t_strb && n < 50) begin
      tick();
      n++;
    end
    chk("to_strb_rise", t_strb, 1);
    n = 0;
    while (t_strb && n < 100) begin
      n++;
      tick();
    end
    chk("to_strb_cycles", n, 16);
    chk("to_err_set", t_err, 1);
    chk("to_strb_low", t_strb, 0);
    chk("to_busy_err", t_busy, 1);
    repeat (3) tick();
    chk("to_err_holds", t_err, 1);
    t_clr = 1'b1;
    tick();
    t_clr = 1'b0;
    chk("to_err_cleared", t_err, 0);
    chk("to_idle_busy", t_busy, 0);
    chk("to_idle_ready", t_ready, 1);

    bq.delete();
    send(32'h01020304, 1'b0);
    n = 0;
    while (!(pd_strb && pd_data == 8'h02) && n < 3000) begin
      tick();
      n++;
    end
    chk("mid_reach_byte2", pd_data, 8'h02);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_strb", pd_strb, 0);
    chk("mid_rst_data", pd_data, 0);
    chk("mid_rst_last", pd_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", word_ready, 0);
    chk("mid_rst_err", timeout_err, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_ready_after", word_ready, 1);
    bq.delete();
    send(32'h0A0B0C0D, 1'b1);
    wait_ready("post_rst_done");
    chk_bytes("post_rst_bytes", 4, {36'd0, 9'h10A, 9'h00B, 9'h00C, 9'h00D});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
